dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One transaction in flight: IDLE (arbitrate/accept) -> ACCESS (one memory cycle) -> RESP (hold until taken).
`ifndef XLEN
`define XLEN 32
`endif

module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [`XLEN-1:0]  p0_req_addr,
    input  logic [`XLEN-1:0]  p0_req_wdata,
    input  logic              p0_req_we,
    output logic              p0_resp_valid,
    input  logic              p0_resp_ready,
    output logic [`XLEN-1:0]  p0_resp_rdata,
    output logic              p0_resp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [`XLEN-1:0]  p1_req_addr,
    input  logic [`XLEN-1:0]  p1_req_wdata,
    input  logic              p1_req_we,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [`XLEN-1:0]  p1_resp_rdata,
    output logic              p1_resp_err,
    output logic [`XLEN-1:0]  mem_addr,
    output logic [`XLEN-1:0]  mem_write_data,
    input  logic [`XLEN-1:0]  mem_read_data,
    output logic              write_en,
    output logic              mem_en
);
    localparam int unsigned XLEN = `XLEN;
    localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant_c;
    logic              accept_c;
    logic              in_range_c;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic              lat_we;
    logic              lat_port;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    assign in_range_c = (lat_addr <= MAX_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, arbitration and all state-decoded outputs
    always_comb begin
        state_nxt      = state;
        grant_c        = 1'b0;
        accept_c       = 1'b0;
        p0_req_ready   = 1'b0;
        p1_req_ready   = 1'b0;
        p0_resp_valid  = 1'b0;
        p1_resp_valid  = 1'b0;
        p0_resp_rdata  = '0;
        p1_resp_rdata  = '0;
        p0_resp_err    = 1'b0;
        p1_resp_err    = 1'b0;
        mem_en         = 1'b0;
        write_en       = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                // Contention goes to the port not granted last; otherwise the lone requester wins
                if (p0_req_valid && p1_req_valid) grant_c = ~last_grant;
                else                              grant_c = p1_req_valid;
                p0_req_ready = !rst && p0_req_valid && !grant_c;
                p1_req_ready = !rst && p1_req_valid && grant_c;
                accept_c     = p0_req_ready || p1_req_ready;
                if (accept_c) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_en         = in_range_c;
                write_en       = in_range_c && lat_we;
                mem_addr       = lat_addr;
                mem_write_data = lat_wdata;
                state_nxt      = RESP;
            end
            RESP: begin
                p0_resp_valid = !lat_port;
                p1_resp_valid = lat_port;
                if (lat_port) begin
                    p1_resp_rdata = resp_data;
                    p1_resp_err   = resp_err;
                    if (p1_resp_ready) state_nxt = IDLE;
                end else begin
                    p0_resp_rdata = resp_data;
                    p0_resp_err   = resp_err;
                    if (p0_resp_ready) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, grant history and response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_port   <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                last_grant <= grant_c;
                lat_port   <= grant_c;
                lat_addr   <= grant_c ? p1_req_addr  : p0_req_addr;
                lat_wdata  <= grant_c ? p1_req_wdata : p0_req_wdata;
                lat_we     <= grant_c ? p1_req_we    : p0_req_we;
            end
            if (state == ACCESS) begin
                resp_err  <= !in_range_c;
                resp_data <= (in_range_c && !lat_we) ? mem_read_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a byte-array memory on the memory side and a
// transaction-level reference (round-robin winner, byte-array image) predicting every response.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req_valid = 0, p0_req_ready, p0_req_we = 0;
    logic [31:0] p0_req_addr = 0, p0_req_wdata = 0;
    logic        p0_resp_valid, p0_resp_ready = 0, p0_resp_err;
    logic [31:0] p0_resp_rdata;
    logic        p1_req_valid = 0, p1_req_ready, p1_req_we = 0;
    logic [31:0] p1_req_addr = 0, p1_req_wdata = 0;
    logic        p1_resp_valid, p1_resp_ready = 0, p1_resp_err;
    logic [31:0] p1_resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        write_en, mem_en;

    int total = 0;
    int bad   = 0;

    logic [7:0] tmem [MEM_BYTES];
    logic [7:0] rmem [MEM_BYTES];
    logic [9:0] ma0, ma1, ma2, ma3;
    int         last_win;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_we(p0_req_we),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready),
        .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_we(p1_req_we),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready),
        .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .write_en(write_en), .mem_en(mem_en)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational little-endian read, write on posedge
    assign ma0 = mem_addr[9:0];
    assign ma1 = ma0 + 10'd1;
    assign ma2 = ma0 + 10'd2;
    assign ma3 = ma0 + 10'd3;
    assign mem_read_data = {tmem[ma3], tmem[ma2], tmem[ma1], tmem[ma0]};

    always @(posedge clk) begin
        if (mem_en && write_en) begin
            tmem[ma0] <= mem_write_data[7:0];
            tmem[ma1] <= mem_write_data[15:8];
            tmem[ma2] <= mem_write_data[23:16];
            tmem[ma3] <= mem_write_data[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input int a);
        return {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
    endfunction

    task automatic ref_write(input int a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) rmem[a+k] = d[8*k +: 8];
    endtask

    // One complete transaction with the reference predicting winner and response
    task automatic do_txn(input logic v0, input logic [31:0] a0, input logic [31:0] d0, input logic w0,
                          input logic v1, input logic [31:0] a1, input logic [31:0] d1, input logic w1,
                          input int hold);
        int          win;
        logic [31:0] a, d, exp_data;
        logic        we, inr;
        if (v0 && v1) win = 1 - last_win;
        else          win = v1 ? 1 : 0;
        a  = win ? a1 : a0;
        d  = win ? d1 : d0;
        we = win ? w1 : w0;
        inr = (a <= 32'(MEM_BYTES - 4));
        exp_data = 32'h0;
        if (inr && !we) exp_data = ref_read(int'(a));
        if (inr && we)  ref_write(int'(a), d);
        last_win = win;

        @(negedge clk);
        p0_req_valid = v0; p0_req_addr = a0; p0_req_wdata = d0; p0_req_we = w0;
        p1_req_valid = v1; p1_req_addr = a1; p1_req_wdata = d1; p1_req_we = w1;
        #1;
        check("req_ready0", 32'(p0_req_ready), 32'(v0 && win == 0));
        check("req_ready1", 32'(p1_req_ready), 32'(v1 && win == 1));
        @(posedge clk);
        @(negedge clk);
        // Requesters change their payload right after acceptance; the access must not care
        p0_req_addr = $urandom; p0_req_wdata = $urandom; p0_req_we = ~w0;
        p1_req_addr = $urandom; p1_req_wdata = $urandom; p1_req_we = ~w1;
        #1;
        check("acc_mem_en", 32'(mem_en), 32'(inr));
        check("acc_write_en", 32'(write_en), 32'(inr && we));
        check("acc_ready", 32'({p0_req_ready, p1_req_ready}), 32'h0);
        if (inr) check("acc_mem_addr", mem_addr, a);
        if (inr && we) check("acc_wdata", mem_write_data, d);
        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            #1;
            check("resp_valid0", 32'(p0_resp_valid), 32'(win == 0));
            check("resp_valid1", 32'(p1_resp_valid), 32'(win == 1));
            check("resp_rdata", win ? p1_resp_rdata : p0_resp_rdata, exp_data);
            check("resp_err", 32'(win ? p1_resp_err : p0_resp_err), 32'(!inr));
            check("resp_no_ready", 32'({p0_req_ready, p1_req_ready}), 32'h0);
            check("resp_mem_en", 32'(mem_en), 32'h0);
            if (c == hold) begin
                p0_resp_ready = 1'b1;
                p1_resp_ready = 1'b1;
            end
        end
        @(negedge clk);
        p0_req_valid = 0; p1_req_valid = 0;
        p0_resp_ready = 0; p1_resp_ready = 0;
        #1;
        check("back_idle", 32'({p0_resp_valid, p1_resp_valid}), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            tmem[i] = 8'($urandom);
            rmem[i] = tmem[i];
        end
        last_win = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", 32'({p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
                                  p0_resp_err, p1_resp_err, mem_en, write_en}), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_outputs", 32'({p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err,
                                       mem_en, write_en}), 32'h0);
        check("post_rst_rdata", p0_resp_rdata | p1_resp_rdata, 32'h0);

        // Write then read back at 0x10 on port 0
        do_txn(1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);
        do_txn(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        // Boundary: 0x3FD out of range, 0x3FC in range, far out of range
        do_txn(0, 0, 0, 0, 1, 32'h3FD, 0, 0, 0);
        do_txn(0, 0, 0, 0, 1, 32'h3FC, 0, 0, 0);
        do_txn(1, 32'h8000_0000, 32'h1234, 1, 0, 0, 0, 0, 1);
        // Unaligned write/read pass through
        do_txn(0, 0, 0, 0, 1, 32'h123, 32'hA5A55A5A, 1, 0);
        do_txn(1, 32'h123, 0, 0, 0, 0, 0, 0, 0);
        // Backpressure: resp_ready held low for 5 cycles
        do_txn(1, 32'h20, 0, 0, 0, 0, 0, 0, 5);
        // Both ports contending continuously: grants must alternate
        for (int i = 0; i < 6; i++)
            do_txn(1, 32'($urandom_range(0, 1020)), 0, 0, 1, 32'($urandom_range(0, 1020)), 0, 0, 0);

        // Reset in the middle of a write access
        @(negedge clk);
        p0_req_valid = 1; p0_req_addr = 32'h40; p0_req_wdata = 32'h12345678; p0_req_we = 1;
        @(posedge clk);
        @(negedge clk);
        p0_req_valid = 0;
        #1;
        check("rstmid_pre_write_en", 32'({mem_en, write_en}), 32'h3);
        rst = 1'b1;
        #1;
        check("rstmid_mem_en", 32'({mem_en, write_en}), 32'h0);
        check("rstmid_resp", 32'({p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_win = 1;
        @(negedge clk);
        #1;
        check("rstmid_no_resp", 32'({p0_resp_valid, p1_resp_valid}), 32'h0);
        do_txn(1, 32'h40, 0, 0, 1, 32'h44, 0, 0, 0);
        do_txn(1, 32'h48, 0, 0, 1, 32'h40, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic        v0, v1;
            logic [31:0] a0, a1;
            int          sel;
            sel = int'($urandom_range(1, 3));
            v0 = sel[0];
            v1 = sel[1];
            a0 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1021, 1100))
                                             : 32'($urandom_range(0, 1020));
            a1 = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(1000, 1020));
            do_txn(v0, a0, $urandom, 1'($urandom), v1, a1, $urandom, 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
